// File: rtl/chacha_round_ctrl.sv
// ChaCha round sequencer: 16-word working store driving an external quarter-round.
// Define CHACHA_FINAL_ADD_EN to build the input snapshot and feed-forward FINAL phase.
module chacha_round_ctrl #(
   parameter int ROUNDS = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic [3:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic [1:0]  qr_sel,
   output logic [31:0] qr_a,
   output logic [31:0] qr_b,
   output logic [31:0] qr_c,
   output logic [31:0] qr_d,
   input  logic [31:0] qr_a_res,
   input  logic [31:0] qr_b_res,
   input  logic [31:0] qr_c_res,
   input  logic [31:0] qr_d_res
);

   localparam int DRW = (ROUNDS / 2 > 1) ? $clog2(ROUNDS / 2) : 1;
   localparam logic [DRW-1:0] DR_LAST = DRW'(ROUNDS / 2 - 1);

`ifdef CHACHA_FINAL_ADD_EN
   typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
`else
   typedef enum logic [1:0] {IDLE, ROUND} state_t;
`endif

   state_t state, state_next;

   logic [31:0]    w [16];
   logic [1:0]     sub;
   logic [2:0]     grp;
   logic [DRW-1:0] dr;
   logic [3:0]     ia, ib, ic, id;
   logic           round_last;
   logic           finish;

`ifdef CHACHA_FINAL_ADD_EN
   logic [31:0]    orig [16];
   logic [3:0]     k;
`endif

   // Groups 0-3 are columns; 4-7 are diagonals, rotating b/c/d rows by 1/2/3.
   always_comb begin
      ia = {2'b00, grp[1:0]};
      ib = {2'b01, grp[1:0]};
      ic = {2'b10, grp[1:0]};
      id = {2'b11, grp[1:0]};
      if (grp[2]) begin
         ib = {2'b01, grp[1:0] + 2'd1};
         ic = {2'b10, grp[1:0] + 2'd2};
         id = {2'b11, grp[1:0] + 2'd3};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      round_last = (state == ROUND) && (sub == 2'd3) && (grp == 3'd7) && (dr == DR_LAST);
      finish     = 1'b0;
      case (state)
         IDLE:  if (start) state_next = ROUND;
         ROUND: begin
            if (round_last) begin
`ifdef CHACHA_FINAL_ADD_EN
               state_next = FINAL;
`else
               state_next = IDLE;
               finish     = 1'b1;
`endif
            end
         end
`ifdef CHACHA_FINAL_ADD_EN
         FINAL: begin
            if (k == 4'd15) begin
               state_next = IDLE;
               finish     = 1'b1;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      qr_sel  = sub;
      qr_a    = w[ia];
      qr_b    = w[ib];
      qr_c    = w[ic];
      qr_d    = w[id];
      rd_data = w[rd_addr];
   end

   // Word store and counters; done is registered so it lands in the first IDLE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) w[i] <= '0;
`ifdef CHACHA_FINAL_ADD_EN
         for (int i = 0; i < 16; i++) orig[i] <= '0;
         k <= '0;
`endif
         sub  <= '0;
         grp  <= '0;
         dr   <= '0;
         done <= 1'b0;
      end else begin
         done <= finish;
         case (state)
            IDLE: begin
               if (wr_en) w[wr_addr] <= wr_data;
               if (start) begin
                  sub <= '0;
                  grp <= '0;
                  dr  <= '0;
`ifdef CHACHA_FINAL_ADD_EN
                  k   <= '0;
                  for (int i = 0; i < 16; i++) orig[i] <= w[i];
                  if (wr_en) orig[wr_addr] <= wr_data;
`endif
               end
            end
            ROUND: begin
               w[ia] <= qr_a_res;
               w[ib] <= qr_b_res;
               w[ic] <= qr_c_res;
               w[id] <= qr_d_res;
               sub   <= sub + 2'd1;
               if (sub == 2'd3) begin
                  grp <= grp + 3'd1;
                  if (grp == 3'd7) dr <= dr + 1'b1;
               end
            end
`ifdef CHACHA_FINAL_ADD_EN
            FINAL: begin
               w[k] <= w[k] + orig[k];
               k    <= k + 4'd1;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chacha_round_ctrl.sv
// Self-checking bench for chacha_round_ctrl with a behavioural quarter-round and ChaCha block model.
// Follows CHACHA_FINAL_ADD_EN for expected latency and feed-forward.
module tb_chacha_round_ctrl;

   localparam int ROUNDS = 20;
`ifdef CHACHA_FINAL_ADD_EN
   localparam int LAT = 16 * ROUNDS + 17;
`else
   localparam int LAT = 16 * ROUNDS + 1;
`endif

   typedef logic [15:0][31:0] blk_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        start = 1'b0;
   logic        busy, done;
   logic [3:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic [1:0]  qr_sel;
   logic [31:0] qr_a, qr_b, qr_c, qr_d;
   logic [31:0] qr_a_res, qr_b_res, qr_c_res, qr_d_res;

   int checks = 0;
   int failures = 0;

   always #50 clk = ~clk;

   chacha_round_ctrl #(.ROUNDS(ROUNDS)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
      .qr_sel(qr_sel), .qr_a(qr_a), .qr_b(qr_b), .qr_c(qr_c), .qr_d(qr_d),
      .qr_a_res(qr_a_res), .qr_b_res(qr_b_res), .qr_c_res(qr_c_res), .qr_d_res(qr_d_res)
   );

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   // Stand-in for the chacha_qr datapath: one quarter-round sub-step per qr_sel.
   always_comb begin
      qr_a_res = qr_a;
      qr_b_res = qr_b;
      qr_c_res = qr_c;
      qr_d_res = qr_d;
      case (qr_sel)
         2'd0: begin qr_a_res = qr_a + qr_b; qr_d_res = rotl(qr_d ^ (qr_a + qr_b), 16); end
         2'd1: begin qr_c_res = qr_c + qr_d; qr_b_res = rotl(qr_b ^ (qr_c + qr_d), 12); end
         2'd2: begin qr_a_res = qr_a + qr_b; qr_d_res = rotl(qr_d ^ (qr_a + qr_b), 8); end
         default: begin qr_c_res = qr_c + qr_d; qr_b_res = rotl(qr_b ^ (qr_c + qr_d), 7); end
      endcase
   end

   function automatic blk_t step_sub(input blk_t s, input int sb, input int a, input int b, input int c, input int d);
      case (sb)
         0: begin s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 16); end
         1: begin s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 12); end
         2: begin s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 8); end
         default: begin s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 7); end
      endcase
      return s;
   endfunction

   function automatic blk_t qround(input blk_t s, input int a, input int b, input int c, input int d);
      s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 16);
      s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 12);
      s[a] = s[a] + s[b]; s[d] = rotl(s[d] ^ s[a], 8);
      s[c] = s[c] + s[d]; s[b] = rotl(s[b] ^ s[c], 7);
      return s;
   endfunction

   function automatic blk_t chacha_ref(input blk_t in);
      blk_t x = in;
      for (int r = 0; r < ROUNDS / 2; r++) begin
         x = qround(x, 0, 4, 8, 12);
         x = qround(x, 1, 5, 9, 13);
         x = qround(x, 2, 6, 10, 14);
         x = qround(x, 3, 7, 11, 15);
         x = qround(x, 0, 5, 10, 15);
         x = qround(x, 1, 6, 11, 12);
         x = qround(x, 2, 7, 8, 13);
         x = qround(x, 3, 4, 9, 14);
      end
`ifdef CHACHA_FINAL_ADD_EN
      for (int i = 0; i < 16; i++) x[i] = x[i] + in[i];
`endif
      return x;
   endfunction

   function automatic blk_t rfc_block();
      blk_t b;
      b[0] = 32'h61707865; b[1] = 32'h3320646e; b[2] = 32'h79622d32; b[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++)
         b[4 + i] = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
      b[12] = 32'h00000001; b[13] = 32'h09000000; b[14] = 32'h4a000000; b[15] = 32'h00000000;
      return b;
   endfunction

   function automatic blk_t rand_block();
      blk_t b;
      for (int i = 0; i < 16; i++) b[i] = $urandom;
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_block(input blk_t b);
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_addr = 4'(i); wr_data = b[i];
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic read_block(output blk_t r);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1;
         r[i] = rd_data;
      end
   endtask

   task automatic start_block();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int from, output int cyc);
      cyc = from;
      while (done !== 1'b1 && cyc < LAT + 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic check_block(input string name, input blk_t got, input blk_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got w0=%h w15=%h expected w0=%h w15=%h", name, got[0], got[15], exp[0], exp[15]);
      end
   endtask

   task automatic check_latency(input string name, input int cyc);
      checks++;
      if (cyc !== LAT || done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s: done seen in cycle %0d (done=%b busy=%b) expected cycle %0d", name, cyc, done, busy, LAT);
      end
   endtask

   task automatic test_reset();
      blk_t r;
      rst = 1'b1;
      tick(); tick();
      read_block(r);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || qr_sel !== 2'd0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: got busy=%b done=%b qr_sel=%0d expected 0 0 0", busy, done, qr_sel);
      end
      checks++;
      if ({qr_a, qr_b, qr_c, qr_d} !== 128'd0) begin
         failures++;
         $display("[TB] FAIL reset_qr: got %h expected 0", {qr_a, qr_b, qr_c, qr_d});
      end
      check_block("reset_words", r, '0);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_rfc();
      blk_t b = rfc_block();
      blk_t r;
      int cyc;
      load_block(b);
      start_block();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL rfc_busy_cycle1: got %b expected 1", busy);
      end
      wait_done(1, cyc);
      check_latency("rfc_latency", cyc);
      read_block(r);
`ifdef CHACHA_FINAL_ADD_EN
      checks++;
      if (r[0] !== 32'he4e7f110 || r[1] !== 32'h15593bd1 || r[15] !== 32'h4e3c50a2) begin
         failures++;
         $display("[TB] FAIL rfc_vector: got %h %h %h expected e4e7f110 15593bd1 4e3c50a2", r[0], r[1], r[15]);
      end
`else
      checks++;
      if (r[0] !== 32'h837778ab || r[1] !== 32'he238d763) begin
         failures++;
         $display("[TB] FAIL rfc_vector: got %h %h expected 837778ab e238d763", r[0], r[1]);
      end
`endif
      check_block("rfc_model", r, chacha_ref(b));
      tick();
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL done_pulse_width: got %b expected 0", done);
      end
   endtask

   task automatic test_sequencing();
      int tab [8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                         '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
      blk_t b = rand_block();
      blk_t m = b;
      blk_t r;
      int cyc, g, s;
      load_block(b);
      start_block();
      for (int c = 1; c <= 24; c++) begin
         g = (c - 1) / 4;
         s = (c - 1) % 4;
         checks++;
         if (qr_sel !== 2'(s) || qr_a !== m[tab[g][0]] || qr_b !== m[tab[g][1]] ||
             qr_c !== m[tab[g][2]] || qr_d !== m[tab[g][3]]) begin
            failures++;
            $display("[TB] FAIL seq_cycle%0d: got sel=%0d a=%h d=%h expected sel=%0d a=%h d=%h",
                     c, qr_sel, qr_a, qr_d, s, m[tab[g][0]], m[tab[g][3]]);
         end
         m = step_sub(m, s, tab[g][0], tab[g][1], tab[g][2], tab[g][3]);
         tick();
      end
      wait_done(25, cyc);
      check_latency("seq_latency", cyc);
      read_block(r);
      check_block("seq_result", r, chacha_ref(b));
   endtask

   task automatic test_random();
      blk_t b, r;
      int cyc;
      for (int n = 0; n < 3; n++) begin
         b = rand_block();
         load_block(b);
         start_block();
         wait_done(1, cyc);
         check_latency("rand_latency", cyc);
         read_block(r);
         check_block("rand_result", r, chacha_ref(b));
      end
   endtask

   task automatic test_write_lockout();
      blk_t b = rfc_block();
      blk_t r;
      int cyc = 1;
      int extra = 0;
      load_block(b);
      start_block();
      while (done !== 1'b1 && cyc < LAT + 40) begin
         wr_en = (cyc == 100);
         wr_addr = 4'd3;
         wr_data = 32'hdeadbeef;
         start = (cyc == 200);
         tick();
         cyc++;
      end
      wr_en = 1'b0;
      start = 1'b0;
      check_latency("lockout_latency", cyc);
      read_block(r);
      check_block("lockout_result", r, chacha_ref(b));
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         failures++;
         $display("[TB] FAIL lockout_no_restart: got %0d busy/done cycles expected 0", extra);
      end
   endtask

   task automatic test_abort();
      blk_t r;
      int cyc, seen;
      load_block(rand_block());
      start_block();
      for (int c = 1; c < 150; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      read_block(r);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL abort_ctrl: got busy=%b done=%b expected 0 0", busy, done);
      end
      check_block("abort_words", r, '0);
      seen = 0;
      for (int i = 0; i < LAT; i++) begin
         tick();
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("[TB] FAIL abort_no_done: got %0d done pulses expected 0", seen);
      end
      load_block(rfc_block());
      start_block();
      wait_done(1, cyc);
      check_latency("abort_rerun_latency", cyc);
      read_block(r);
`ifdef CHACHA_FINAL_ADD_EN
      checks++;
      if (r[0] !== 32'he4e7f110) begin
         failures++;
         $display("[TB] FAIL abort_rerun_w0: got %h expected e4e7f110", r[0]);
      end
`else
      checks++;
      if (r[0] !== 32'h837778ab) begin
         failures++;
         $display("[TB] FAIL abort_rerun_w0: got %h expected 837778ab", r[0]);
      end
`endif
   endtask

   task automatic test_back_to_back();
      blk_t b = rand_block();
      blk_t r;
      int cyc;
      load_block(b);
      start_block();
      wait_done(1, cyc);
      check_latency("b2b_first_latency", cyc);
      start_block();
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL b2b_start_in_done: got busy=%b expected 1", busy);
      end
      wait_done(1, cyc);
      check_latency("b2b_second_latency", cyc);
      read_block(r);
      check_block("b2b_chained_result", r, chacha_ref(chacha_ref(b)));
   endtask

   initial begin
      $display("[TB] chacha_round_ctrl bench, ROUNDS=%0d, done cycle %0d", ROUNDS, LAT);
      test_reset();
      test_rfc();
      test_sequencing();
      test_random();
      test_write_lockout();
      test_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
